// File: rtl/fetch_pkg.sv
// fetch_pkg: types and defaults shared by the fetch unit and its instruction buffer.
// Buffer entries are stored at FETCH_W bits; fetch_unit supports DATA_WIDTH <= FETCH_W.
package fetch_pkg;

  localparam int unsigned FETCH_W = 32;

  localparam logic [FETCH_W-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction ROM request/response bus. The fetch unit is the master;
// the ROM returns imem_rdata exactly one cycle after an accepted imem_req.
interface fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: BUF_DEPTH-entry FIFO of {pc, instr}. BUF_DEPTH must be 2 or 4 so the
// pointers wrap naturally. clear has priority over push and pop.
module fetch_buffer import fetch_pkg::*; #(
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  fetch_entry_t     mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // control: pointers and occupancy, cleared by reset or flush
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // storage: data entries are never reset, only validated by count_q
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, BOOT/FETCH/FLUSH control and instruction buffer feeding.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: when defined, a redirect whose target
// is not word-aligned is rejected and fetch_fault pulses for one cycle; when undefined,
// the target's low two bits are cleared and fetch_fault is tied low.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(FETCH_RESET_PC),
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_if.master               imem,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] req_pc_p1;

  logic [CNT_W-1:0]      buf_count;
  logic                  buf_push, buf_pop, buf_clear;
  fetch_entry_t          buf_head, buf_wdata;
  logic [CNT_W:0]        occupancy;

  logic                  redir_take;
  logic [DATA_WIDTH-1:0] redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign redir_take   = redirect && (state_q != ST_BOOT) && (redirect_pc[1:0] == 2'b00);
  assign fault_d      = redirect && (state_q != ST_BOOT) && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;

  // fault register: one-cycle pulse after a rejected misaligned redirect
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return a & ~DATA_WIDTH'(3);
  endfunction

  assign redir_take   = redirect && (state_q != ST_BOOT);
  assign redir_target = word_align(redirect_pc);
  assign fetch_fault  = 1'b0;
`endif

  // Entries already buffered plus the one in flight, less the one leaving this cycle.
  assign buf_pop   = instr_valid && instr_ready;
  assign occupancy = {1'b0, buf_count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(buf_pop);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // next-state: a redirect in FLUSH keeps the unit in FLUSH for one more cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (redir_take) state_d = ST_FLUSH;
      ST_FLUSH: if (!redir_take) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // outputs: request issue, buffer push/clear and next PC
  always_comb begin
    imem.imem_req = 1'b0;
    buf_push      = 1'b0;
    buf_clear     = 1'b0;
    pc_d          = pc_q;
    case (state_q)
      ST_FETCH: begin
        if (redir_take) begin
          buf_clear = 1'b1;
          pc_d      = redir_target;
        end else begin
          buf_push = vld_p1;
          if (occupancy < (CNT_W+1)'(BUF_DEPTH)) begin
            imem.imem_req = 1'b1;
            pc_d          = pc_q + DATA_WIDTH'(4);
          end
        end
      end
      ST_FLUSH: if (redir_take) pc_d = redir_target;
      default: ;
    endcase
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // stage p0 -> p1: request in flight; a request pending at reset is dropped
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= imem.imem_req;
  end

  // stage p0 -> p1: address of the request, paired with the returning ROM word
  always_ff @(posedge clk) begin
    req_pc_p1 <= pc_q;
  end

  assign imem.imem_addr = pc_q;
  assign buf_wdata      = '{pc: FETCH_W'(req_pc_p1), instr: FETCH_W'(imem.imem_rdata)};

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .clear_i (buf_clear),
    .wdata_i (buf_wdata),
    .head_o  (buf_head),
    .count_o (buf_count)
  );

  assign instr_valid = (buf_count != '0);
  assign instr       = DATA_WIDTH'(buf_head.instr);
  assign instr_pc    = DATA_WIDTH'(buf_head.pc);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of instruction word and PC.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 imem_req  out  1  read request to instruction ROM this cycle.
REQ-008 imem_addr  out  DATA_WIDTH  byte address of request; word-aligned.
REQ-009 imem_rdata  in  DATA_WIDTH  ROM data; valid exactly 1 cycle after the accepted imem_req.
REQ-010 instr  out  DATA_WIDTH  instruction word presented to the decoder.
REQ-011 instr_pc  out  DATA_WIDTH  address of instr.
REQ-012 instr_valid  out  1  instr/instr_pc hold a live instruction.
REQ-013 instr_ready  in  1  decode stage accepts; transfer when instr_valid & instr_ready.
REQ-014 redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-015 redirect_pc  in  DATA_WIDTH  target address.
REQ-016 fetch_fault  out  1  one-cycle pulse on rejected misaligned redirect (only with macro, REQ-032).

Function
REQ-017 FSM states: BOOT, FETCH, FLUSH; encoding from the shared package.
REQ-018 BOOT: entered on reset; no request; next cycle -> FETCH.
REQ-019 FETCH: imem_req=1 iff (count + inflight - pop) < BUF_DEPTH, where pop = instr_valid & instr_ready; imem_addr = pc; pc += 4 on each request.
REQ-020 Response cycle (inflight=1, state FETCH): push {pc_of_request, imem_rdata} into buffer.
REQ-021 Buffer: FIFO, head drives instr/instr_pc; instr_valid = (count != 0); push and pop in same cycle leave count unchanged.
REQ-022 Buffer full: no request issued (REQ-019 guarantees no push on full); no overflow possible.
REQ-023 Buffer empty: instr_valid=0; instr/instr_pc content don't-care.
REQ-024 redirect in FETCH: buffer cleared, pc <= redirect_pc, state -> FLUSH, imem_req=0 that cycle.
REQ-025 FLUSH: any response arriving is discarded; no request; next cycle -> FETCH and request redirect_pc.
REQ-026 redirect with simultaneous handshake: the transfer counts as accepted; all remaining entries dropped.
REQ-027 redirect in FLUSH: pc updated to newest redirect_pc; stays FLUSH one further cycle.
REQ-028 redirect in BOOT: ignored.
REQ-029 PC arithmetic modulo 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0 without flag.
REQ-030 Throughput: with instr_ready held 1, one instr_valid transfer per cycle from the third cycle after FETCH entry.

Reset
REQ-031 While rst=1 at a clock edge: state=BOOT, pc=RESET_PC, count=0, inflight=0, imem_req=0, instr_valid=0, fetch_fault=0; response of a request pending at reset is discarded; rst overrides redirect.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 is rejected: pc, buffer, and state unchanged, fetch_fault pulses 1 cycle.
REQ-033 Macro not defined: redirect_pc[1:0] forced to 2'b00 and redirect proceeds; fetch_fault tied 0.

Structure
REQ-034 Package fetch_pkg SHALL hold FSM state enum, buffer entry struct {pc, instr}, and the RESET_PC default constant.
REQ-035 Sub-module fetch_buffer SHALL implement the BUF_DEPTH FIFO with push, pop, clear, count; FSM and PC remain in fetch_unit.

Verification
REQ-036 Reset release, RESET_PC=0, instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_pc 0,4,8 with matching ROM words, no gaps after fill.
REQ-037 instr_ready=0 for 5 cycles -> exactly BUF_DEPTH requests then imem_req=0; on release, instr_pc continues in order, no loss or duplicate.
REQ-038 redirect to 0x100 while buffer holds 0x8,0xC -> no further transfer of 0x8/0xC/0x10, FLUSH 1 cycle, next imem_addr=0x100, first instr_pc after=0x100.
REQ-039 redirect and handshake same cycle at instr_pc=0x20, target 0x40 -> 0x20 accepted once, next transfer instr_pc=0x40.
REQ-040 redirect_pc=0x102: with FETCH_MISALIGN_TRAP_EN -> fetch_fault 1 cycle, sequence continues unchanged; without -> next imem_addr=0x100.
REQ-041 RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-stream -> instr_valid=0 next cycle, refetch from RESET_PC.
